// File: rtl/arb_pkg.sv
// Shared types, constants and helpers for the four-requester arbiter.
// Consumed by req_arbiter4 and arb_prio_enc via import arb_pkg::*.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot4(input logic [ID_W-1:0] id);
        onehot4 = 4'b0001 << id;
    endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// Combinational 4-to-2 priority encoder, highest index wins after rotating
// the vector by rot; rot=0 gives fixed priority 3>2>1>0.
module arb_prio_enc
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    input  logic [ID_W-1:0]  rot,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    logic [N_REQ-1:0] rotated;
    logic [ID_W-1:0]  pos;

    always_comb begin
        rotated = '0;
        pos     = '0;
        // Position j holds requester (j+rot) mod 4, so requester rot-1 lands on top.
        for (int j = 0; j < N_REQ; j++) begin
            rotated[j] = vec[ID_W'(j) + rot];
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (rotated[j]) begin
                pos = ID_W'(j);
            end
        end
        idx = pos + rot;
        any = |vec;
    end

endmodule

// File: rtl/req_arbiter4.sv
// Four-requester arbiter with grant locking, MAX_HOLD force-release and mask.
// Define REQ_ARBITER4_ROUND_ROBIN_EN to rotate priority after every grant.
module req_arbiter4
    import arb_pkg::*;
#(
    parameter  int MAX_HOLD = 16,
    localparam int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] cand;
    logic [ID_W-1:0]  rot;
    logic [ID_W-1:0]  win_id;
    logic             win_any;

    always_comb begin
        eligible = req & ~mask_q;
        // The mask only steers between competitors; a lone requester still wins.
        cand     = (eligible == '0) ? req : eligible;
`ifdef REQ_ARBITER4_ROUND_ROBIN_EN
        rot      = last_id_q;
`else
        rot      = '0;
`endif
    end

    arb_prio_enc u_prio_enc (
        .vec (cand),
        .rot (rot),
        .idx (win_id),
        .any (win_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            mask_q      <= '0;
            last_id_q   <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            mask_q      <= mask_d;
            last_id_q   <= last_id_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        mask_d      = mask_q;
        last_id_d   = last_id_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                if (win_any) begin
                    gnt_d       = onehot4(win_id);
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    mask_d      = '0;
                    state_d     = GRANT;
`ifdef REQ_ARBITER4_ROUND_ROBIN_EN
                    last_id_d   = win_id;
`endif
                end
            end
            GRANT: begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
                // A release in the limit cycle wins over the timeout.
                if (!req[gnt_id_q]) begin
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                    mask_d      = onehot4(gnt_id_q);
                    last_id_d   = gnt_id_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        gnt_id    = gnt_id_q;
        gnt_valid = gnt_valid_q;
        timeout   = timeout_q;
    end

endmodule

// File: tb/tb_req_arbiter4.sv
// Directed self-checking bench for req_arbiter4 (MAX_HOLD=16).
// Observed vector layout: {gnt[3:0], gnt_id[1:0], gnt_valid, timeout}.
module tb_req_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    logic [7:0] obs;

    int total = 0;
    int bad   = 0;

    req_arbiter4 #(.MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    assign obs = {gnt, gnt_id, gnt_valid, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        total++;
        if (obs !== 8'b0000_00_0_0) begin
            bad++;
            $display("FAIL reset_hold: got %b want %b", obs, 8'b0000_00_0_0);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (obs !== 8'b0000_00_0_0) begin
                bad++;
                $display("FAIL idle_c%0d: got %b want %b", c, obs, 8'b0000_00_0_0);
            end
        end
    endtask

    task automatic test_fixed_priority();
        req = 4'b0110;
        tick();
        total++;
        if (obs !== 8'b0100_10_1_0) begin
            bad++;
            $display("FAIL fixed_first: got %b want %b", obs, 8'b0100_10_1_0);
        end
        req = 4'b1110;
        tick();
        total++;
        if (obs !== 8'b0100_10_1_0) begin
            bad++;
            $display("FAIL fixed_no_preempt: got %b want %b", obs, 8'b0100_10_1_0);
        end
        req = 4'b0010;
        tick();
        total++;
        if (obs !== 8'b0000_00_0_0) begin
            bad++;
            $display("FAIL fixed_gap: got %b want %b", obs, 8'b0000_00_0_0);
        end
        tick();
        total++;
        if (obs !== 8'b0010_01_1_0) begin
            bad++;
            $display("FAIL fixed_second: got %b want %b", obs, 8'b0010_01_1_0);
        end
        req = 4'b0000;
        tick();
        tick();
        total++;
        if (obs !== 8'b0000_00_0_0) begin
            bad++;
            $display("FAIL fixed_idle: got %b want %b", obs, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_hold_limit();
        int held;
        held = 0;
        req  = 4'b1001;
        tick();
        for (int c = 1; c <= 16; c++) begin
            if (obs === 8'b1000_11_1_0) held++;
            tick();
        end
        total++;
        if (held != 16) begin
            bad++;
            $display("FAIL hold_cycles: got %0d want %0d", held, 16);
        end
        total++;
        if (obs !== 8'b0000_00_0_1) begin
            bad++;
            $display("FAIL hold_timeout: got %b want %b", obs, 8'b0000_00_0_1);
        end
        tick();
        total++;
        if (obs !== 8'b0001_00_1_0) begin
            bad++;
            $display("FAIL hold_masked_regrant: got %b want %b", obs, 8'b0001_00_1_0);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_lone_timeout();
        int held;
        held = 0;
        req  = 4'b0100;
        tick();
        for (int c = 1; c <= 16; c++) begin
            if (obs === 8'b0100_10_1_0) held++;
            tick();
        end
        total++;
        if (held != 16) begin
            bad++;
            $display("FAIL lone_cycles: got %0d want %0d", held, 16);
        end
        total++;
        if (obs !== 8'b0000_00_0_1) begin
            bad++;
            $display("FAIL lone_timeout: got %b want %b", obs, 8'b0000_00_0_1);
        end
        tick();
        total++;
        if (obs !== 8'b0100_10_1_0) begin
            bad++;
            $display("FAIL lone_regrant: got %b want %b", obs, 8'b0100_10_1_0);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_release_at_limit();
        req = 4'b1001;
        tick();
        for (int c = 1; c <= 15; c++) begin
            tick();
        end
        total++;
        if (obs !== 8'b1000_11_1_0) begin
            bad++;
            $display("FAIL coinc_c16: got %b want %b", obs, 8'b1000_11_1_0);
        end
        req = 4'b0001;
        tick();
        total++;
        if (obs !== 8'b0000_00_0_0) begin
            bad++;
            $display("FAIL coinc_no_timeout: got %b want %b", obs, 8'b0000_00_0_0);
        end
        req = 4'b1001;
        tick();
        total++;
        if (obs !== 8'b1000_11_1_0) begin
            bad++;
            $display("FAIL coinc_unmasked: got %b want %b", obs, 8'b1000_11_1_0);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        req = 4'b1000;
        tick();
        total++;
        if (obs !== 8'b1000_11_1_0) begin
            bad++;
            $display("FAIL areset_pre: got %b want %b", obs, 8'b1000_11_1_0);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== 8'b0000_00_0_0) begin
            bad++;
            $display("FAIL areset_immediate: got %b want %b", obs, 8'b0000_00_0_0);
        end
        #2;
        rst = 1'b0;
        req = 4'b0001;
        tick();
        total++;
        if (obs !== 8'b0001_00_1_0) begin
            bad++;
            $display("FAIL areset_regrant: got %b want %b", obs, 8'b0001_00_1_0);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int         exp_ids[5];
        logic [3:0] oh;
        logic [1:0] id;
`ifdef REQ_ARBITER4_ROUND_ROBIN_EN
        exp_ids = '{3, 2, 1, 0, 3};
`else
        exp_ids = '{3, 3, 3, 3, 3};
`endif
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            id = 2'(exp_ids[k]);
            oh = 4'b0001 << id;
            total++;
            if (obs !== {oh, id, 2'b10}) begin
                bad++;
                $display("FAIL b2b_owner%0d: got %b want %b", k, obs, {oh, id, 2'b10});
            end
            tick();
            req = 4'b1111 & ~oh;
            tick();
            total++;
            if (obs !== 8'b0000_00_0_0) begin
                bad++;
                $display("FAIL b2b_gap%0d: got %b want %b", k, obs, 8'b0000_00_0_0);
            end
            req = 4'b1111;
            tick();
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        test_reset();
        test_fixed_priority();
        test_hold_limit();
        test_lone_timeout();
        test_release_at_limit();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
